// File: rtl/mux4x1_pkg.sv
//==============================================================================
// Module      : mux4x1_pkg
// Description : Shared types, constants and helpers for the 4:1 mux
//               round-robin arbiter (state enum, requester count, select
//               encoding and the rotating priority search).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mux4x1_pkg;

  // Number of requesters, one per mux data input (x1..x4).
  localparam int NUM_REQ = 4;

  // Arbiter ownership state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Result of a priority search: winner index plus a valid flag.
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Requester index to mux select pair {s2,s1}: x1=00, x2=01, x3=10, x4=11.
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    return idx;
  endfunction

  // First set bit of req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // The loop runs from the lowest priority up so the highest priority
  // candidate is the last one written.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [1:0]         ptr);
    pick_t      res;
    logic [1:0] cand;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4x1.sv
//==============================================================================
// Module      : mux4x1
// Description : Plain 4:1 multiplexer. {s2,s1} = 00/01/10/11 selects
//               x1/x2/x3/x4 onto f.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux4x1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] f
);

  // Route the selected data input to the output.
  always_comb begin
    f = x1;
    case ({s2, s1})
      2'b00:   f = x1;
      2'b01:   f = x2;
      2'b10:   f = x3;
      default: f = x4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux4x1_rr_arbiter_rr_pick4.sv
//==============================================================================
// Module      : rr_pick4
// Description : Combinational rotating-priority search over four request
//               lines. Returns the first set request at or after ptr_i.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick4
  import mux4x1_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic               found_o,
  output logic [1:0]         idx_o
);

  pick_t w_pick;

  // Search the candidate vector starting from the priority pointer.
  always_comb begin
    w_pick = rr_pick(req_i, ptr_i);
  end

  assign found_o = w_pick.found;
  assign idx_o   = w_pick.idx;

endmodule

`default_nettype wire

// File: rtl/mux4x1_rr_arbiter.sv
//==============================================================================
// Module      : mux4x1_rr_arbiter
// Description : Round-robin arbiter sharing a 4:1 mux among four requesters.
//               Grants one owner at a time, drives the mux select pair
//               {s2,s1} for that owner, and hands over to the next pending
//               requester on the same edge the owner releases.
//               Optional feature macro: MUX4X1_ARB_TIMEOUT_EN - when defined,
//               an owner that has held the grant for MAX_HOLD cycles is
//               revoked if another requester is waiting.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux4x1_rr_arbiter
  import mux4x1_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s2,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [1:0]         ptr_q,   ptr_d;
  logic [NUM_REQ-1:0] gnt_q,   gnt_d;
  logic [1:0]         sel_q,   sel_d;
  logic               busy_q,  busy_d;

  // Candidates exclude the current owner, so a winner here always means
  // "someone else is waiting". In IDLE gnt_q is zero and all requests compete.
  logic [NUM_REQ-1:0] cand_req;
  logic               owner_req;
  logic               win_found;
  logic [1:0]         win_idx;
  logic               take_new;
  logic               revoke;

  assign cand_req  = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);

  rr_pick4 u_pick (
    .req_i   (cand_req),
    .ptr_i   (ptr_q),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  // Out-of-range MAX_HOLD values (legal 2..255) have no defined behaviour;
  // this empty block only anchors the parameter for elaboration in every build.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
  end

`ifdef MUX4X1_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_expired;

  // cnt_q counts completed owner cycles beyond the first, so the owner has
  // had MAX_HOLD cycles of grant when cnt_q reaches MAX_HOLD-1.
  assign hold_expired = (cnt_q >= CW'(MAX_HOLD - 1));
  assign revoke       = hold_expired & win_found;

  // Hold counter: cleared on each new grant and on idle, saturates at MAX_HOLD.
  always_comb begin
    cnt_d = cnt_q;
    if (take_new) begin
      cnt_d = '0;
    end else if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q < CW'(MAX_HOLD)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign revoke = 1'b0;
`endif

  // Ownership next-state: keep, hand over without a bubble, or go idle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    take_new = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          take_new = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req || revoke) begin
          if (win_found) begin
            take_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (take_new) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win_idx;
      sel_d   = idx_to_sel(win_idx);
      ptr_d   = win_idx + 2'd1;
      busy_d  = 1'b1;
    end
  end

  // State, pointer and registered outputs; reset clears any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= '0;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign {s2, s1} = sel_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: doc/mux4x1_rr_arbiter.md
# mux4x1_rr_arbiter

Round-robin arbiter that shares the 4:1 multiplexer among four requesters. It samples one request line per mux input, grants exactly one requester at a time, and drives the mux select pair (s2, s1) so the granted input reaches `f`. It sits directly in front of `mux4x1` and is its only source of select values.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when contention exists; legal range 2..255; used only when the timeout feature is compiled in.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low; one clock domain only.
- `req` input 4: request per mux input; bit 0 = x1, bit 1 = x2, bit 2 = x3, bit 3 = x4. A requester holds its bit high until it is finished.
- `gnt` output 4: one-hot grant, same bit mapping as `req`; all-zero when idle.
- `s1` output 1: mux select LSB.
- `s2` output 1: mux select MSB.
- `busy` output 1: high while any grant is active.

## Operation
- Select encoding: {s2,s1} = 00 selects x1, 01 selects x2, 10 selects x3, 11 selects x4.
- When `gnt` is zero, {s2,s1} holds its last value.
- States:
  - IDLE: no owner.
  - GRANT: one owner.
- Priority pointer `ptr` (2 bits) names the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- IDLE → GRANT: any `req` bit high. The winner is the first set bit in search order, and `ptr` becomes winner+1 mod 4.
- In GRANT, while the owner's `req` stays high, the grant and selects hold.
- Owner drops `req`:
  - If other requests are pending, the next winner is granted on the same edge (GRANT → GRANT, no bubble cycle), and `ptr` updates as above.
  - If no other requests are pending, the block goes GRANT → IDLE.
- Requests from non-owners never preempt the owner, except through the timeout described under Configuration.
- A requester that drops `req` before it is granted loses its claim. No request is latched.
- `gnt`, `s1`, `s2` and `busy` are registered outputs. There is no combinational path from `req` to any output.

## Timing
- Reset values: `gnt`=0000, s1=0, s2=0, `busy`=0, `ptr`=0, state IDLE, hold counter 0.
- Reset is asynchronous on assertion. Deassertion is sampled at the next rising edge of `clk`.
- Reset mid-grant clears everything immediately, with no completion of the current grant.
- Latency: `req` high at edge N gives `gnt` and selects valid after edge N (visible in cycle N+1).
- Release: owner `req` low at edge N causes `gnt` to change after edge N.
- When several requests rise on the same edge from IDLE, the search order from `ptr` decides the winner.
- `ptr` wraps from 3 to 0.
- Invariant: `gnt` is always one-hot or zero.
- Invariant: `busy` equals OR(`gnt`).
- Invariant: {s2,s1} equals the index of the set `gnt` bit whenever `busy` is high.

## Configuration
- Macro: `MUX4X1_ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter of $clog2(MAX_HOLD+1) bits counts owner cycles. It is cleared on every new grant.
  - When the count reaches MAX_HOLD and any other `req` is high, the owner is revoked on that edge and the next winner in search order is granted.
  - The revoked owner may re-win later by keeping its `req` high.
  - With no contention, the counter saturates at MAX_HOLD and the grant holds.
- Undefined:
  - No counter is built; `MAX_HOLD` is ignored.
  - The owner holds the grant until it drops its `req`.

## Structure
- Shared package `mux4x1_pkg` contains:
  - the state enum (IDLE, GRANT);
  - the constant NUM_REQ = 4;
  - the function `idx_to_sel` (2-bit index to {s2,s1});
  - the function `rr_pick` (req vector plus ptr to winner index and a found flag).
- One sub-module, `rr_pick4`: the combinational priority search for the winner index.
- The top level holds the state register, `ptr`, the grant/select registers and the optional hold counter.
- Bench arrangement: the bench instantiates `mux4x1_rr_arbiter` driving the s1/s2 inputs of `mux4x1`, with x1..x4 tied to distinct patterns.

## Test plan
- Reset: assert `rst_n`=0 mid-grant (`gnt`=0100). Required: `gnt`=0000, s2s1=00 and `busy`=0 immediately; after release, a pending `req`=0001 gives `gnt`=0001 after the next edge.
- Single requester: `req`=0100 for 5 cycles, then 0000. Required: `gnt`=0100 and s2s1=10 one cycle after `req`, `f` follows x3; IDLE one cycle after the drop.
- Rotation: `req`=1111 held, each owner drops for one cycle after being granted. Required grant order 0001, 0010, 0100, 1000, 0001, with no idle cycle between grants.
- Simultaneous request after wrap: `ptr`=3 (last grant was x3), then `req`=1001. Required: `gnt`=1000 first, then 0001.
- Timeout (with `MUX4X1_ARB_TIMEOUT_EN`, MAX_HOLD=4): `req`=0011 held. Required: `gnt`=0001 for 4 cycles, then 0010 for 4, then 0001.
- No-timeout build, same stimulus as the timeout test. Required: `gnt`=0001 persists for 20+ cycles.
